grafica_desplazamiento_multi: RTL and testbench

Parametrised multi-channel scrolling strip-chart plotter for the VGA speed display. On each sample strobe it renders one full column, one bit per channel, into an internal dual-port framebuffer of ANCHO x ALTO words, CANALES bits wide. Each sample column overwrites the oldest column. The pixel read port serves the VGA pixel generator and returns RGB332 colour. Optional scroll mode re-maps reads so the newest sample always sits at the right edge.

---
 rtl/grafica_desplazamiento_multi_if.sv | 27 ++
 rtl/grafica_desplazamiento_multi.sv | 181 ++++++++++++++++++
 tb/tb_grafica_desplazamiento_multi.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grafica_desplazamiento_multi_if.sv
// Sample and pixel bus for the scrolling strip-chart plotter.
//   master: sample source / pixel reader (drives strobe, samples, mode, read coordinates)
//   slave : plotter (returns pixel colour, busy flag and dropped-sample pulse)
interface grafica_desplazamiento_multi_if #(
    parameter int unsigned CANALES = 2,
    parameter int unsigned DATA_W  = 16
);
    logic                        muestra_valida;
    logic [CANALES*DATA_W-1:0]   muestras;
    logic                        modo;
    logic                        desplazar;
    logic [9:0]                  rd_x;
    logic [9:0]                  rd_y;
    logic [7:0]                  dout;
    logic                        ocupado;
    logic                        muestra_perdida;

    modport master (
        output muestra_valida, muestras, modo, desplazar, rd_x, rd_y,
        input  dout, ocupado, muestra_perdida
    );

    modport slave (
        input  muestra_valida, muestras, modo, desplazar, rd_x, rd_y,
        output dout, ocupado, muestra_perdida
    );
endinterface

// File: rtl/grafica_desplazamiento_multi.sv
// Multi-channel scrolling strip-chart plotter.
// Each accepted sample renders one full column (one bit per channel per row) into an
// ANCHO x ALTO framebuffer, overwriting the oldest column. A 2-cycle read port returns
// RGB332 colour, optionally re-mapped so the newest column sits at rd_x = ANCHO-1.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : muestra_valida/muestras/modo in, desplazar/rd_x/rd_y in,
//                  dout/ocupado/muestra_perdida out
module grafica_desplazamiento_multi #(
    parameter int unsigned          ANCHO   = 300,
    parameter int unsigned          ALTO    = 100,
    parameter int unsigned          CANALES = 2,
    parameter int unsigned          DATA_W  = 16,
    parameter int unsigned          ESCALA  = 0,
    parameter logic [CANALES*8-1:0] COLORES = {8'h1C, 8'hE0}
) (
    input logic                           clock,
    input logic                           reset,
    grafica_desplazamiento_multi_if.slave bus
);
    localparam int unsigned Pixeles = ANCHO * ALTO;
    localparam int unsigned AW      = $clog2(Pixeles);
    localparam int unsigned XW      = $clog2(ANCHO);
    localparam int unsigned YW      = $clog2(ALTO);
    localparam int unsigned VW      = DATA_W + 32;

    localparam logic [AW-1:0] UltimaDir  = AW'(Pixeles - 1);
    localparam logic [XW-1:0] UltimaCol  = XW'(ANCHO - 1);
    localparam logic [YW-1:0] UltimaFila = YW'(ALTO - 1);

    typedef enum logic [1:0] {StLimpiar, StIdle, StColumna} estadoT;

    logic [CANALES-1:0] memoria [Pixeles];

    estadoT                      estadoQ, estadoD;
    logic [AW-1:0]               dirQ, dirD;          // write address (clear and column)
    logic [YW-1:0]               filaQ, filaD;        // row being written in the column
    logic [XW-1:0]               cursorQ, cursorD;    // column receiving the next sample
    logic [CANALES-1:0][YW-1:0]  umbralQ, umbralD;    // trace row per channel
    logic                        modoQ, modoD;
    logic                        perdidaQ, perdidaD;
    logic                        escribir;
    logic [CANALES-1:0]          palabra;

    // Row (0 = top) where a sample lands: scale, clip to the plot height, flip.
    function automatic logic [YW-1:0] filaDe(input logic [DATA_W-1:0] m);
        logic [VW-1:0] v;
        v = VW'(m) >> ESCALA;
        if (v >= VW'(ALTO)) begin
            return '0;
        end
        return YW'(VW'(ALTO - 1) - v);
    endfunction

    always_comb begin
        estadoD  = estadoQ;
        dirD     = dirQ;
        filaD    = filaQ;
        cursorD  = cursorQ;
        umbralD  = umbralQ;
        modoD    = modoQ;
        escribir = 1'b0;
        perdidaD = bus.muestra_valida && (estadoQ != StIdle);
        unique case (estadoQ)
            StLimpiar: begin
                escribir = 1'b1;
                if (dirQ == UltimaDir) begin
                    dirD    = '0;
                    estadoD = StIdle;
                end else begin
                    dirD = dirQ + 1'b1;
                end
            end
            StIdle: begin
                if (bus.muestra_valida) begin
                    for (int unsigned c = 0; c < CANALES; c++) begin
                        umbralD[c] = filaDe(bus.muestras[c*DATA_W +: DATA_W]);
                    end
                    modoD   = bus.modo;
                    filaD   = '0;
                    dirD    = AW'(cursorQ);
                    estadoD = StColumna;
                end
            end
            StColumna: begin
                escribir = 1'b1;
                if (filaQ == UltimaFila) begin
                    filaD   = '0;
                    cursorD = (cursorQ == UltimaCol) ? '0 : cursorQ + 1'b1;
                    estadoD = StIdle;
                end else begin
                    filaD = filaQ + 1'b1;
                    dirD  = dirQ + AW'(ANCHO);   // next row, same column
                end
            end
            default: estadoD = StLimpiar;
        endcase
    end

    // Every row of the column is written, so unlit bits erase the old column.
    always_comb begin
        palabra = '0;
        for (int unsigned c = 0; c < CANALES; c++) begin
            if (estadoQ == StColumna) begin
                palabra[c] = modoQ ? (filaQ >= umbralQ[c]) : (filaQ == umbralQ[c]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estadoQ  <= StLimpiar;
            dirQ     <= '0;
            filaQ    <= '0;
            cursorQ  <= '0;
            umbralQ  <= '0;
            modoQ    <= 1'b0;
            perdidaQ <= 1'b0;
        end else begin
            estadoQ  <= estadoD;
            dirQ     <= dirD;
            filaQ    <= filaD;
            cursorQ  <= cursorD;
            umbralQ  <= umbralD;
            modoQ    <= modoD;
            perdidaQ <= perdidaD;
        end
    end

    // Read stage 1: physical address and range flag.
    logic [10:0]   sumaX;
    logic [9:0]    px;
    logic          enRango;
    logic [AW-1:0] dirLecD, dirLecQ;
    logic          rangoQ1, rangoQ2;
    logic [CANALES-1:0] lecturaQ;

    always_comb begin
        sumaX = {1'b0, bus.rd_x} + 11'(cursorQ);
        px    = bus.rd_x;
        if (bus.desplazar) begin
            px = (sumaX >= 11'(ANCHO)) ? 10'(sumaX - 11'(ANCHO)) : sumaX[9:0];
        end
        enRango = (bus.rd_x < 10'(ANCHO)) && (bus.rd_y < 10'(ALTO));
        dirLecD = enRango ? AW'(bus.rd_y) * AW'(ANCHO) + AW'(px) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dirLecQ <= '0;
            rangoQ1 <= 1'b0;
            rangoQ2 <= 1'b0;
        end else begin
            dirLecQ <= dirLecD;
            rangoQ1 <= enRango;
            rangoQ2 <= rangoQ1;
        end
    end

    // Stage 2: single RAM process; non-blocking read gives read-first on collision.
    always_ff @(posedge clock) begin
        if (escribir && !reset) begin
            memoria[dirQ] <= palabra;
        end
        lecturaQ <= memoria[dirLecQ];
    end

    always_comb begin
        bus.dout = '0;
        if ((estadoQ != StLimpiar) && rangoQ2) begin
            for (int unsigned c = 0; c < CANALES; c++) begin
                if (lecturaQ[c]) begin
                    bus.dout = bus.dout | COLORES[c*8 +: 8];
                end
            end
        end
    end

    assign bus.ocupado         = (estadoQ != StIdle);
    assign bus.muestra_perdida = perdidaQ;
endmodule

// File: tb/tb_grafica_desplazamiento_multi.sv
module tb_grafica_desplazamiento_multi;
    localparam int ANCHO = 300;
    localparam int ALTO  = 100;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic resetB = 1'b1;
    always #5 clock = ~clock;

    grafica_desplazamiento_multi_if #(.CANALES(2), .DATA_W(16)) busA ();
    grafica_desplazamiento_multi_if #(.CANALES(2), .DATA_W(16)) busB ();

    grafica_desplazamiento_multi dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    grafica_desplazamiento_multi #(.ESCALA(2)) dutB (
        .clock (clock),
        .reset (resetB),
        .bus   (busB)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model for dutA: the sample values and mode stored per column.
    int mV0 [ANCHO];
    int mV1 [ANCHO];
    bit mModo [ANCHO];
    bit mSet [ANCHO];
    int mCur = 0;

    typedef struct {
        int         x;
        int         y;
        bit         desp;
        logic [7:0] exp;
    } vecT;
    vecT tabla [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] colour(input int c);
        return (c == 0) ? 8'hE0 : 8'h1C;
    endfunction

    // Pixel as a plot: row y is height ALTO-1-y above the baseline; a point trace lights
    // the height equal to the clipped sample, a bar lights every height up to it.
    function automatic logic [7:0] modelPix(input int x, input int y, input bit desp);
        logic [7:0] p;
        int px, lvl, v;
        p = 8'h00;
        if (x >= ANCHO || y >= ALTO) return 8'h00;
        px = desp ? (x + mCur) % ANCHO : x;
        if (!mSet[px]) return 8'h00;
        lvl = ALTO - 1 - y;
        for (int c = 0; c < 2; c++) begin
            v = (c == 0) ? mV0[px] : mV1[px];
            if (v > ALTO - 1) v = ALTO - 1;
            if (mModo[px] ? (lvl <= v) : (lvl == v)) p = p | colour(c);
        end
        return p;
    endfunction

    task automatic strobeA(input int v0, input int v1, input bit modo);
        busA.muestras       = {16'(v1), 16'(v0)};
        busA.modo           = modo;
        busA.muestra_valida = 1'b1;
        tick();
        busA.muestra_valida = 1'b0;
        repeat (ALTO - 1) tick();
        check("ocupado mid-column", 32'(busA.ocupado), 32'd1);
        tick();
        check("ocupado after column", 32'(busA.ocupado), 32'd0);
        mV0[mCur] = v0;
        mV1[mCur] = v1;
        mModo[mCur] = modo;
        mSet[mCur] = 1'b1;
        mCur = (mCur + 1) % ANCHO;
    endtask

    task automatic readA(input int x, input int y, input bit desp, output logic [7:0] d);
        busA.rd_x      = 10'(x);
        busA.rd_y      = 10'(y);
        busA.desplazar = desp;
        tick();
        tick();
        d = busA.dout;
    endtask

    task automatic readB(input int x, input int y, input bit desp, output logic [7:0] d);
        busB.rd_x      = 10'(x);
        busB.rd_y      = 10'(y);
        busB.desplazar = desp;
        tick();
        tick();
        d = busB.dout;
    endtask

    task automatic randomReadsA(input int count);
        logic [7:0] d;
        int x, y;
        bit desp;
        for (int i = 0; i < count; i++) begin
            x    = $urandom_range(0, ANCHO + 10);
            y    = $urandom_range(0, ALTO + 5);
            desp = 1'($urandom_range(0, 1));
            readA(x, y, desp, d);
            check($sformatf("random read (%0d,%0d,d%0d)", x, y, desp), 32'(d),
                  32'(modelPix(x, y, desp)));
        end
    endtask

    initial begin
        logic [7:0] d;
        int n;

        // Expected pixels after three strobes: (0,40) point, (500,99) point, (30,0) bar.
        tabla[0]  = '{0, 99, 1'b0, 8'hE0};
        tabla[1]  = '{0, 59, 1'b0, 8'h1C};
        tabla[2]  = '{0, 58, 1'b0, 8'h00};
        tabla[3]  = '{1, 0, 1'b0, 8'hFC};
        tabla[4]  = '{1, 1, 1'b0, 8'h00};
        tabla[5]  = '{2, 68, 1'b0, 8'h00};
        tabla[6]  = '{2, 69, 1'b0, 8'hE0};
        tabla[7]  = '{2, 98, 1'b0, 8'hE0};
        tabla[8]  = '{2, 99, 1'b0, 8'hFC};
        tabla[9]  = '{3, 50, 1'b0, 8'h00};
        tabla[10] = '{300, 0, 1'b0, 8'h00};
        tabla[11] = '{0, 100, 1'b0, 8'h00};
        tabla[12] = '{1023, 1023, 1'b0, 8'h00};
        tabla[13] = '{299, 69, 1'b1, 8'hE0};
        tabla[14] = '{298, 0, 1'b1, 8'hFC};
        tabla[15] = '{297, 99, 1'b1, 8'hE0};

        for (int i = 0; i < ANCHO; i++) begin
            mSet[i] = 1'b0;
            mV0[i] = 0;
            mV1[i] = 0;
            mModo[i] = 1'b0;
        end
        busA.muestra_valida = 1'b0; busA.muestras = '0; busA.modo = 1'b0;
        busA.desplazar = 1'b0; busA.rd_x = '0; busA.rd_y = '0;
        busB.muestra_valida = 1'b0; busB.muestras = '0; busB.modo = 1'b0;
        busB.desplazar = 1'b0; busB.rd_x = '0; busB.rd_y = '0;

        // Reset, with a strobe in the last reset cycle which must be ignored.
        repeat (2) tick();
        busA.muestra_valida = 1'b1;
        tick();
        busA.muestra_valida = 1'b0;
        reset  = 1'b0;
        resetB = 1'b0;
        check("ocupado after reset", 32'(busA.ocupado), 32'd1);
        check("dout after reset", 32'(busA.dout), 32'd0);
        check("perdida after reset strobe", 32'(busA.muestra_perdida), 32'd0);

        // Clear length; a strobe during the clear is dropped with a pulse.
        n = 0;
        while (busA.ocupado && n < 40000) begin
            if (n == 1000) busA.muestra_valida = 1'b1;
            tick();
            if (n == 1000) begin
                busA.muestra_valida = 1'b0;
                check("perdida during clear", 32'(busA.muestra_perdida), 32'd1);
            end
            n++;
        end
        check("clear cycles", 32'(n), 32'd30000);
        check("perdida idle", 32'(busA.muestra_perdida), 32'd0);
        check("dutB idle after clear", 32'(busB.ocupado), 32'd0);
        randomReadsA(16);

        // Point mode, cursor advance.
        strobeA(0, 40, 1'b0);
        readA(299, 99, 1'b1, d);
        check("newest column after 1 strobe", 32'(d), 32'hE0);
        readA(0, 99, 1'b1, d);
        check("scrolled column 0 after 1 strobe", 32'(d), 32'h00);

        strobeA(500, 99, 1'b0);
        strobeA(30, 0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            readA(tabla[i].x, tabla[i].y, tabla[i].desp, d);
            check($sformatf("vec%0d (%0d,%0d,d%0d)", i, tabla[i].x, tabla[i].y, tabla[i].desp),
                  32'(d), 32'(tabla[i].exp));
        end

        // ESCALA=2 instance: 40>>2 = 10 lands on row 89.
        busB.muestras = {16'd0, 16'd40};
        busB.modo = 1'b0;
        busB.muestra_valida = 1'b1;
        tick();
        busB.muestra_valida = 1'b0;
        repeat (ALTO) tick();
        readB(0, 89, 1'b0, d); check("escala row 89", 32'(d), 32'hE0);
        readB(0, 88, 1'b0, d); check("escala row 88", 32'(d), 32'h00);
        readB(0, 90, 1'b0, d); check("escala row 90", 32'(d), 32'h00);
        readB(0, 99, 1'b0, d); check("escala ch1 row 99", 32'(d), 32'h1C);

        // Strobe 10 cycles after the previous one is dropped; latched values kept.
        n = mCur;
        busA.muestras = {16'd20, 16'd10};
        busA.modo = 1'b0;
        busA.muestra_valida = 1'b1;
        tick();
        busA.muestra_valida = 1'b0;
        check("no drop on accepted strobe", 32'(busA.muestra_perdida), 32'd0);
        repeat (9) tick();
        busA.muestras = {16'd70, 16'd70};
        busA.modo = 1'b1;
        busA.muestra_valida = 1'b1;
        tick();
        busA.muestra_valida = 1'b0;
        check("drop pulse", 32'(busA.muestra_perdida), 32'd1);
        tick();
        check("drop pulse width", 32'(busA.muestra_perdida), 32'd0);
        repeat (ALTO + 1 - 12) tick();
        check("ocupado after dropped strobe column", 32'(busA.ocupado), 32'd0);
        mV0[n] = 10; mV1[n] = 20; mModo[n] = 1'b0; mSet[n] = 1'b1;
        mCur = (mCur + 1) % ANCHO;
        readA(n, 89, 1'b0, d); check("kept ch0 row", 32'(d), 32'hE0);
        readA(n, 79, 1'b0, d); check("kept ch1 row", 32'(d), 32'h1C);
        readA(n, 29, 1'b0, d); check("dropped sample absent", 32'(d), 32'h00);
        readA(n, 95, 1'b0, d); check("dropped mode absent", 32'(d), 32'h00);

        // Random columns against the model.
        for (int i = 0; i < 20; i++) begin
            strobeA($urandom_range(0, 140), $urandom_range(0, 140), 1'($urandom_range(0, 1)));
        end
        randomReadsA(150);

        fork
            begin
                // 301 strobes: the pointer advances by one column net.
                for (int k = 1; k <= 301; k++) begin
                    strobeA(k % 100, (k * 37) % 100, 1'b0);
                end
                readA(299, 98, 1'b1, d); check("newest ch0 at rd_x 299", 32'(d), 32'hE0);
                readA(299, 62, 1'b1, d); check("newest ch1 at rd_x 299", 32'(d), 32'h1C);
                readA(299, 97, 1'b1, d); check("newest blank row", 32'(d), 32'h00);
                readA(0, 97, 1'b1, d);   check("strobe 2 ch0 at rd_x 0", 32'(d), 32'hE0);
                readA(0, 25, 1'b1, d);   check("strobe 2 ch1 at rd_x 0", 32'(d), 32'h1C);
                randomReadsA(40);
            end
            begin
                logic [7:0] db;
                int nb;
                // Reset dutB while its column is at row 50.
                busB.muestras = {16'd200, 16'd200};
                busB.modo = 1'b1;
                busB.muestra_valida = 1'b1;
                tick();
                busB.muestra_valida = 1'b0;
                repeat (50) tick();
                resetB = 1'b1;
                tick();
                resetB = 1'b0;
                check("B ocupado after mid-column reset", 32'(busB.ocupado), 32'd1);
                check("B dout after mid-column reset", 32'(busB.dout), 32'd0);
                nb = 0;
                while (busB.ocupado && nb < 40000) begin
                    tick();
                    nb++;
                end
                check("B clear cycles after reset", 32'(nb), 32'd30000);
                for (int x = 0; x < 2; x++) begin
                    for (int y = 0; y < ALTO; y++) begin
                        readB(x, y, 1'b0, db);
                        check($sformatf("B cleared (%0d,%0d)", x, y), 32'(db), 32'h00);
                    end
                end
                for (int i = 0; i < 30; i++) begin
                    readB($urandom_range(0, ANCHO - 1), $urandom_range(0, ALTO - 1),
                          1'($urandom_range(0, 1)), db);
                    check("B cleared random", 32'(db), 32'h00);
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
